// File: rtl/l1_data_cache.sv
// l1_data_cache: direct-mapped, write-through, write-allocate L1 data cache between a word-wide CPU port and a block-wide L2.
// Ports:
//   clk, rst_n                  clock (rising edge) and asynchronous active-low reset
//   cpu_req/we/addr/wdata       CPU request, sampled only in IDLE
//   cpu_ready/rdata/hit         one-cycle completion pulse, load data (held), hit qualifier
//   l2_read/write/addr/wdata    level-held block fetch / block write towards L2
//   l2_rdata, l2_ready          fetched block and L2 completion
//   hit_count, miss_count       saturating 16-bit lookup statistics, present only with L1_STATS_EN defined
module l1_data_cache #(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 11,
   parameter int BLOCK_WORDS = 8,
   parameter int NUM_LINES   = 8
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              cpu_req,
   input  logic                              cpu_we,
   input  logic [ADDR_WIDTH-1:0]             cpu_addr,
   input  logic [DATA_WIDTH-1:0]             cpu_wdata,
   output logic                              cpu_ready,
   output logic [DATA_WIDTH-1:0]             cpu_rdata,
   output logic                              cpu_hit,
   output logic                              l2_read,
   output logic                              l2_write,
   output logic [ADDR_WIDTH-1:0]             l2_addr,
   output logic [BLOCK_WORDS*DATA_WIDTH-1:0] l2_wdata,
`ifdef L1_STATS_EN
   output logic [15:0]                       hit_count,
   output logic [15:0]                       miss_count,
`endif
   input  logic [BLOCK_WORDS*DATA_WIDTH-1:0] l2_rdata,
   input  logic                              l2_ready
);
   localparam int OW = $clog2(BLOCK_WORDS);
   localparam int IW = $clog2(NUM_LINES);
   localparam int TW = ADDR_WIDTH - OW - IW;
   localparam int BW = BLOCK_WORDS * DATA_WIDTH;

   typedef enum logic [1:0] {IDLE, LOOKUP, FILL, WRITE_L2} state_t;

   state_t                state, state_nx;
   logic                  look, look_nx;
   logic                  hit_q, hit_q_nx;
   logic                  we_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [NUM_LINES-1:0]  valid;
   logic [TW-1:0]         tags [NUM_LINES];
   logic [BW-1:0]         data [NUM_LINES];
   logic                  rd_valid;
   logic [TW-1:0]         rd_tag;
   logic [BW-1:0]         rd_blk;
   logic [OW-1:0]         off;
   logic [IW-1:0]         idx;
   logic [TW-1:0]         tag;
   logic [ADDR_WIDTH-1:0] blk_addr;
   logic                  hit;
   logic                  ln_we;
   logic [BW-1:0]         ln_blk, hit_m, fill_m;
   logic                  ready_nx, chit_nx, l2r_nx, l2w_nx;
   logic [DATA_WIDTH-1:0] rdata_nx;
   logic [ADDR_WIDTH-1:0] l2a_nx;
   logic [BW-1:0]         l2d_nx;

   assign off      = addr_q[OW-1:0];
   assign idx      = addr_q[OW+IW-1:OW];
   assign tag      = addr_q[ADDR_WIDTH-1:OW+IW];
   assign blk_addr = {addr_q[ADDR_WIDTH-1:OW], {OW{1'b0}}};
   // Line contents are registered in the first LOOKUP cycle so the tag compare sees flopped data.
   assign hit      = rd_valid && rd_tag == tag;

   always_comb begin
      state_nx = state;
      look_nx  = look;
      hit_q_nx = hit_q;
      ready_nx = 1'b0;
      rdata_nx = cpu_rdata;
      chit_nx  = cpu_hit;
      l2r_nx   = l2_read;
      l2w_nx   = l2_write;
      l2a_nx   = l2_addr;
      l2d_nx   = l2_wdata;
      ln_we    = 1'b0;
      hit_m    = rd_blk;
      hit_m[off*DATA_WIDTH +: DATA_WIDTH] = wdata_q;
      fill_m   = l2_rdata;
      fill_m[off*DATA_WIDTH +: DATA_WIDTH] = wdata_q;
      ln_blk   = hit_m;
      case (state)
         IDLE: begin
            look_nx  = 1'b0;
            state_nx = cpu_req ? LOOKUP : IDLE;
         end
         LOOKUP: begin
            look_nx = 1'b1;
            if (look && hit && !we_q) begin
               ready_nx = 1'b1;
               rdata_nx = rd_blk[off*DATA_WIDTH +: DATA_WIDTH];
               chit_nx  = 1'b1;
               state_nx = IDLE;
            end else if (look && hit) begin
               ln_we    = 1'b1;
               l2a_nx   = blk_addr;
               l2d_nx   = hit_m;
               l2w_nx   = 1'b1;
               hit_q_nx = 1'b1;
               state_nx = WRITE_L2;
            end else if (look) begin
               l2a_nx   = blk_addr;
               l2r_nx   = 1'b1;
               hit_q_nx = 1'b0;
               state_nx = FILL;
            end
         end
         FILL: begin
            if (l2_ready) begin
               l2r_nx   = 1'b0;
               ln_we    = 1'b1;
               ln_blk   = we_q ? fill_m : l2_rdata;
               ready_nx = !we_q;
               rdata_nx = we_q ? cpu_rdata : l2_rdata[off*DATA_WIDTH +: DATA_WIDTH];
               chit_nx  = we_q ? cpu_hit : 1'b0;
               l2d_nx   = we_q ? fill_m : l2_wdata;
               l2w_nx   = we_q;
               state_nx = we_q ? WRITE_L2 : IDLE;
            end
         end
         WRITE_L2: begin
            if (l2_ready) begin
               l2w_nx   = 1'b0;
               ready_nx = 1'b1;
               chit_nx  = hit_q;
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         look      <= 1'b0;
         hit_q     <= 1'b0;
         valid     <= '0;
         rd_valid  <= 1'b0;
         cpu_ready <= 1'b0;
         cpu_rdata <= '0;
         cpu_hit   <= 1'b0;
         l2_read   <= 1'b0;
         l2_write  <= 1'b0;
         l2_addr   <= '0;
         l2_wdata  <= '0;
      end else begin
         state     <= state_nx;
         look      <= look_nx;
         hit_q     <= hit_q_nx;
         cpu_ready <= ready_nx;
         cpu_rdata <= rdata_nx;
         cpu_hit   <= chit_nx;
         l2_read   <= l2r_nx;
         l2_write  <= l2w_nx;
         l2_addr   <= l2a_nx;
         l2_wdata  <= l2d_nx;
         if (state == LOOKUP && !look) rd_valid <= valid[idx];
         if (ln_we) valid[idx] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (state == IDLE && cpu_req) begin
         we_q    <= cpu_we;
         addr_q  <= cpu_addr;
         wdata_q <= cpu_wdata;
      end
      if (state == LOOKUP && !look) begin
         rd_tag <= tags[idx];
         rd_blk <= data[idx];
      end
      if (ln_we) begin
         tags[idx] <= tag;
         data[idx] <= ln_blk;
      end
   end

`ifdef L1_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else if (state == LOOKUP && look) begin
         if (hit && hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
         if (!hit && miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
      end
   end
`endif
endmodule

// File: tb/tb_l1_data_cache.sv
// tb_l1_data_cache: directed plus randomized bench for l1_data_cache against a line-tag/golden-memory model.
module tb_l1_data_cache;
   logic         clk = 0;
   logic         rst_n, cpu_req, cpu_we;
   logic [10:0]  cpu_addr;
   logic [31:0]  cpu_wdata;
   logic         cpu_ready, cpu_hit, l2_read, l2_write, l2_ready;
   logic [31:0]  cpu_rdata;
   logic [10:0]  l2_addr;
   logic [255:0] l2_wdata, l2_rdata;
`ifdef L1_STATS_EN
   logic [15:0]  hit_count, miss_count;
`endif

   l1_data_cache dut (
      .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata), .cpu_hit(cpu_hit),
      .l2_read(l2_read), .l2_write(l2_write), .l2_addr(l2_addr), .l2_wdata(l2_wdata),
`ifdef L1_STATS_EN
      .hit_count(hit_count), .miss_count(miss_count),
`endif
      .l2_rdata(l2_rdata), .l2_ready(l2_ready)
   );

   always #5 clk = ~clk;

   int           vectors = 0, errors = 0;
   int           lat = 3, cnt = 0, n_rd = 0, n_wr = 0, wr_at_done = 0, hc = 0, mc = 0;
   logic [10:0]  rd_addr, wr_addr;
   logic [255:0] wr_blk;
   logic [31:0]  l2_mem [2048];
   logic [31:0]  gold [2048];
   bit   [7:0]   rv;
   bit   [4:0]   rt [8];

   task automatic chk(input string nm, input logic [255:0] obs, input logic [255:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
      end
   endtask

   // L2 model: answers each level-held request after lat cycles with a one-cycle l2_ready.
   initial begin
      l2_ready = 0;
      l2_rdata = '0;
      forever begin
         @(posedge clk);
         #1;
         chk("l2_exclusive", l2_read & l2_write, 0);
         if (!rst_n || l2_ready) begin
            l2_ready = 0;
            cnt = 0;
         end else if (l2_read || l2_write) begin
            cnt++;
            if (cnt >= lat) begin
               l2_ready = 1;
               cnt = 0;
               if (l2_read) begin
                  for (int i = 0; i < 8; i++) l2_rdata[i*32 +: 32] = l2_mem[l2_addr + 11'(i)];
                  n_rd++;
                  rd_addr = l2_addr;
               end else begin
                  for (int i = 0; i < 8; i++) l2_mem[l2_addr + 11'(i)] = l2_wdata[i*32 +: 32];
                  n_wr++;
                  wr_addr = l2_addr;
                  wr_blk = l2_wdata;
               end
            end
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst_n = 0;
      rv = '0;
      hc = 0;
      mc = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1;
   endtask

   task automatic op(input bit we, input logic [10:0] a, input logic [31:0] d);
      int cyc;
      bit saw, eh;
      eh = rv[a[5:3]] && rt[a[5:3]] == a[10:6];
      @(negedge clk);
      cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
      @(posedge clk);
      #1;
      cpu_req = 0; cpu_we = 1'($urandom); cpu_addr = 11'($urandom); cpu_wdata = $urandom;
      cyc = 0;
      saw = 0;
      while (!cpu_ready && cyc < 200) begin
         @(posedge clk);
         #1;
         cyc++;
         saw |= l2_read | l2_write;
      end
      wr_at_done = n_wr;
      chk("ready", cpu_ready, 1);
      chk("hit", cpu_hit, eh);
      if (!we) chk("rdata", cpu_rdata, gold[a]);
      if (!we && eh) begin
         chk("hit_latency", cyc, 2);
         chk("hit_no_l2", saw, 0);
      end
      if (eh) hc++; else mc++;
      rv[a[5:3]] = 1;
      rt[a[5:3]] = a[10:6];
      if (we) begin
         gold[a] = d;
         chk("l2_mem_written", l2_mem[a], d);
      end
      @(posedge clk);
      #1;
      chk("ready_pulse", cpu_ready, 0);
      if (!we) chk("rdata_held", cpu_rdata, gold[a]);
`ifdef L1_STATS_EN
      chk("hit_count", hit_count, hc);
      chk("miss_count", miss_count, mc);
`endif
   endtask

   initial begin
      int r0, w0;
      logic [255:0] exp_blk;
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int r0, w0;
      logic [255:0] exp_blk;
      rst_n = 0; cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
      for (int i = 0; i < 2048; i++) l2_mem[i] = $urandom;
      for (int i = 0; i < 8; i++) l2_mem[64+i] = 32'h1000 + i;
      for (int i = 0; i < 2048; i++) gold[i] = l2_mem[i];
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", {cpu_ready, cpu_hit, l2_read, l2_write, cpu_rdata, l2_addr}, 0);
      chk("reset_wdata", l2_wdata, 0);
      @(negedge clk);
      rst_n = 1;
      // 1: cold load miss
      r0 = n_rd;
      op(0, 11'h043, 0);
      chk("t1_reads", n_rd - r0, 1);
      chk("t1_l2_addr", rd_addr, 11'h040);
      chk("t1_rdata", cpu_rdata, 32'h1003);
      // 2: load hit, no L2 traffic
      r0 = n_rd; w0 = n_wr;
      op(0, 11'h045, 0);
      chk("t2_no_l2", {n_rd - r0, n_wr - w0}, 0);
      chk("t2_rdata", cpu_rdata, 32'h1005);
      // 3: store hit writes the whole updated block through
      lat = 2;
      w0 = n_wr;
      op(1, 11'h042, 32'hDEADBEEF);
      chk("t3_write_before_ready", wr_at_done - w0, 1);
      chk("t3_l2_addr", wr_addr, 11'h040);
      for (int i = 0; i < 8; i++) exp_blk[i*32 +: 32] = 32'h1000 + i;
      exp_blk[95:64] = 32'hDEADBEEF;
      chk("t3_l2_wdata", wr_blk, exp_blk);
      op(0, 11'h042, 0);
      chk("t3_reload", cpu_rdata, 32'hDEADBEEF);
      // 4: conflicting tags in index 0 evict each other
      r0 = n_rd;
      op(0, 11'h440, 0);
      op(0, 11'h040, 0);
      chk("t4_reads", n_rd - r0, 2);
      // randomized traffic over four tags so hits and conflicts both occur
      repeat (200) begin
         lat = $urandom_range(1, 4);
         op(1'($urandom_range(0, 1)), 11'(($urandom_range(0, 3) << 6) | $urandom_range(0, 63)), $urandom);
      end
      // 5: store miss after reset fetches then writes the merged block
      do_reset();
      lat = 2;
      r0 = n_rd; w0 = n_wr;
      op(1, 11'h100, 32'h55);
      chk("t5_reads", n_rd - r0, 1);
      chk("t5_read_addr", rd_addr, 11'h100);
      chk("t5_writes", n_wr - w0, 1);
      chk("t5_write_addr", wr_addr, 11'h100);
      chk("t5_word0", wr_blk[31:0], 32'h55);
      for (int i = 0; i < 8; i++) exp_blk[i*32 +: 32] = gold[256+i];
      chk("t5_block", wr_blk, exp_blk);
      // 6: reset during FILL aborts the fill
      lat = 1000;
      @(negedge clk);
      cpu_req = 1; cpu_we = 0; cpu_addr = 11'h043;
      @(posedge clk);
      #1;
      cpu_req = 0;
      repeat (4) @(posedge clk);
      #1;
      chk("t6_in_fill", {l2_read, cpu_ready}, 2'b10);
      @(negedge clk);
      rst_n = 0;
      rv = '0; hc = 0; mc = 0;
      #1;
      chk("t6_outputs_zero", {cpu_ready, cpu_hit, l2_read, l2_write, cpu_rdata, l2_addr}, 0);
      chk("t6_wdata_zero", l2_wdata, 0);
`ifdef L1_STATS_EN
      chk("t6_counters", {hit_count, miss_count}, 0);
`endif
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1;
      lat = 3;
      r0 = n_rd;
      op(0, 11'h043, 0);
      chk("t6_miss_again", n_rd - r0, 1);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
